// File: rtl/mac_accum_8x8_if.sv
// Operand and result handshakes of the 8x8 multiply-accumulate stage.
// The master drives operands and accepts results; the slave is the MAC.
interface mac_accum_8x8_if #(
   parameter int ACC_W = 18
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       a;
   logic [7:0]       b;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic             out_overflow;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, out_sum, out_overflow
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, out_sum, out_overflow
   );
endinterface

// File: rtl/mac_accum_8x8.sv
// Dot-product stage: registers operand pairs, multiplies them 8x8
// unsigned and accumulates LEN products into one handshaked result.
module mac_accum_8x8 #(
   parameter int LEN   = 4,
   parameter int ACC_W = 18
) (
   input logic           clk,
   input logic           rst,
   mac_accum_8x8_if.slave bus
);
   localparam int CW = $clog2(LEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t           state;
   state_t           nstate;
   logic [CW-1:0]    cnt;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic [7:0]       a_q;
   logic [7:0]       b_q;
   logic             pv;
   logic [15:0]      p;
   logic [ACC_W:0]   sum;
   logic             in_rdy;
   logic             o_vld;
   logic             in_hs;
   logic             out_hs;
   logic             last;

   // Array multiplier: sum of shifted partial products of the held pair.
   always_comb begin
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b_q[i]) p = p + (16'(a_q) << i);
      end
   end

   assign in_hs  = bus.in_valid & in_rdy;
   assign out_hs = o_vld & bus.out_ready;
   assign last   = (cnt == CW'(LEN - 1));
   assign sum    = {1'b0, acc} + (ACC_W + 1)'(p);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    nstate = RUN;
         RUN:     if (in_hs && last) nstate = DRAIN;
         DRAIN:   nstate = DONE;
         DONE:    if (bus.out_ready) nstate = RUN;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      in_rdy = 1'b0;
      o_vld  = 1'b0;
      unique case (state)
         RUN:     in_rdy = 1'b1;
         DONE:    o_vld  = 1'b1;
         default: ;
      endcase
   end

   // pv marks a freshly captured pair whose product lands next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         acc <= '0;
         ovf <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         pv  <= 1'b0;
      end else begin
         pv <= in_hs;
         if (pv) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
         end
         if (in_hs) begin
            a_q <= bus.a;
            b_q <= bus.b;
            cnt <= cnt + 1'b1;
         end
         if (out_hs) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
         end
      end
   end

   assign bus.in_ready     = in_rdy;
   assign bus.out_valid    = o_vld;
   assign bus.out_sum      = acc;
   assign bus.out_overflow = ovf;
endmodule

// File: tb/tb_mac_accum_8x8.sv
// Directed and random runs of the 8x8 MAC stage against a dot-product
// model, on an 18-bit and a 16-bit accumulator instance.
module tb_mac_accum_8x8;
   localparam int LEN = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   logic [7:0]  qa[$];
   logic [7:0]  qb[$];
   bit          vpat[$];
   logic [63:0] exp_sum;
   logic        exp_ovf;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_accum_8x8_if #(.ACC_W(18)) b18 ();
   mac_accum_8x8_if #(.ACC_W(16)) b16 ();

   mac_accum_8x8 #(.LEN(LEN), .ACC_W(18)) u18 (
      .clk(clk),
      .rst(rst),
      .bus(b18.slave)
   );

   mac_accum_8x8 #(.LEN(LEN), .ACC_W(16)) u16 (
      .clk(clk),
      .rst(rst),
      .bus(b16.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic drive(input bit w, input bit v, input logic [7:0] x,
                        input logic [7:0] y);
      b18.in_valid = v && !w;
      b16.in_valid = v && w;
      b18.a = x;
      b18.b = y;
      b16.a = x;
      b16.b = y;
   endtask

   task automatic setor(input bit v);
      b18.out_ready = v;
      b16.out_ready = v;
   endtask

   function automatic logic ir(input bit w);
      return w ? b16.in_ready : b18.in_ready;
   endfunction

   function automatic logic ov(input bit w);
      return w ? b16.out_valid : b18.out_valid;
   endfunction

   function automatic logic [63:0] so(input bit w);
      return w ? 64'(b16.out_sum) : 64'(b18.out_sum);
   endfunction

   function automatic logic [63:0] fo(input bit w);
      return w ? 64'(b16.out_overflow) : 64'(b18.out_overflow);
   endfunction

   // Feed qa/qb (in_valid shaped by vpat, then held high) and check result.
   task automatic run(input bit w, input bit lat, input bit hold);
      int          n = 0;
      int          idx = 0;
      int          pi = 0;
      int          t = 0;
      int          k = -1;
      int          e;
      int          nz = 0;
      int          wd;
      logic [63:0] tot = 0;
      bit          v;
      wd = w ? 16 : 18;
      setor(!hold);
      while (n < LEN && t < 300) begin
         v = (pi < vpat.size()) ? vpat[pi] : 1'b1;
         pi++;
         drive(w, v, qa[idx], qb[idx]);
         if (v && ir(w)) begin
            if (k < 0) k = cyc + 1;
            tot += 64'(qa[idx]) * 64'(qb[idx]);
            idx++;
            n++;
         end
         @(negedge clk);
         t++;
      end
      drive(w, 1'b0, 8'd0, 8'd0);
      while (!ov(w) && t < 300) begin
         if (!ir(w)) nz++;
         @(negedge clk);
         t++;
      end
      total++;
      assert (t < 300) else begin
         bad++;
         $error("FAIL timeout observed=%0d expected<300", t);
      end
      e = cyc;
      exp_sum = tot % (64'd1 << wd);
      exp_ovf = (tot >= (64'd1 << wd));
      chk("sum", so(w), exp_sum);
      chk("ovf", fo(w), 64'(exp_ovf));
      if (lat) chk("latency", 64'(e - k), 64'(LEN));
      if (!hold) begin
         if (!ir(w)) nz++;
         @(negedge clk);
         chk("busy_cycles", 64'(nz), 64'd2);
         chk("valid_pulse", 64'(ov(w)), 64'd0);
         chk("ready_again", 64'(ir(w)), 64'd1);
      end
   endtask

   initial begin
      int n;
      int t;
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      setor(1'b1);
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(b18.in_ready), 64'd0);
      chk("rst_out_valid", 64'(b18.out_valid), 64'd0);
      chk("rst_out_sum", so(0), 64'd0);
      chk("rst_ovf", fo(0), 64'd0);
      chk("rst16_in_ready", 64'(b16.in_ready), 64'd0);
      rst = 1'b0;

      qa = '{3, 10, 255, 0};
      qb = '{5, 20, 255, 7};
      vpat = {};
      run(1'b0, 1'b1, 1'b0);
      chk("mixed_65240", exp_sum, 64'd65240);

      qa = '{255, 255, 255, 255};
      qb = '{255, 255, 255, 255};
      run(1'b0, 1'b1, 1'b0);
      chk("max_260100", exp_sum, 64'd260100);

      qa = '{255, 255, 1, 0};
      qb = '{255, 255, 1, 0};
      run(1'b1, 1'b1, 1'b0);
      chk("wrap16_sum", exp_sum, 64'd64515);
      qa = '{1, 1, 1, 1};
      qb = '{1, 1, 1, 1};
      run(1'b1, 1'b1, 1'b0);

      qa = '{9, 8, 7, 6};
      qb = '{1, 2, 3, 4};
      run(1'b0, 1'b0, 1'b1);
      qa = '{7, 100, 200, 50};
      qb = '{9, 3, 2, 1};
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, qa[0], qb[0]);
         chk("bp_valid", 64'(b18.out_valid), 64'd1);
         chk("bp_sum", so(0), 64'd70);
         chk("bp_in_ready", 64'(b18.in_ready), 64'd0);
         @(negedge clk);
      end
      run(1'b0, 1'b0, 1'b0);
      chk("bp_next_sum", so(0) | exp_sum, 64'd813);

      qa = '{2, 3, 4, 5};
      qb = '{2, 3, 4, 5};
      vpat = '{1, 0, 0, 1, 0, 1, 1};
      run(1'b0, 1'b0, 1'b0);
      chk("gaps_54", exp_sum, 64'd54);
      vpat = {};

      n = 0;
      t = 0;
      while (n < 2 && t < 50) begin
         drive(1'b0, 1'b1, 8'd9, 8'd9);
         if (b18.in_ready) n++;
         @(negedge clk);
         t++;
      end
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      chk("mid_accepts", 64'(n), 64'd2);
      rst = 1'b1;
      #1;
      chk("mid_in_ready", 64'(b18.in_ready), 64'd0);
      chk("mid_out_valid", 64'(b18.out_valid), 64'd0);
      chk("mid_out_sum", so(0), 64'd0);
      chk("mid_ovf", fo(0), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("idle_in_ready", 64'(b18.in_ready), 64'd0);
      qa = '{1, 1, 1, 1};
      qb = '{1, 1, 1, 1};
      run(1'b0, 1'b0, 1'b0);
      chk("fresh_4", exp_sum, 64'd4);

      for (int r = 0; r < 8; r++) begin
         qa = {};
         qb = {};
         vpat = {};
         for (int i = 0; i < LEN; i++) begin
            qa.push_back(8'($urandom_range(0, 255)));
            qb.push_back(8'($urandom_range(0, 255)));
         end
         repeat ($urandom_range(0, 5)) vpat.push_back(1'($urandom_range(0, 1)));
         run(1'(r % 2), 1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
